// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder: the MMIO word addresses at
// the top of the dmem address space, the bit layout of the STATUS register and
// the select type used by the load-data multiplexer.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

  // MMIO window occupies the three highest word addresses
  localparam logic [11:0] MMIO_STATUS  = 12'hFFD;
  localparam logic [11:0] MMIO_CYCLES  = 12'hFFE;
  localparam logic [11:0] MMIO_CONSOLE = 12'hFFF;

  // STATUS = {23'b0, overflow, count[7:0]}
  localparam int STATUS_COUNT_LSB = 0;
  localparam int STATUS_COUNT_W   = 8;
  localparam int STATUS_OVF_BIT   = 8;

  // Source selected for the registered load data
  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_STATUS,
    SEL_CYCLES,
    SEL_CONSOLE
  } rd_sel_e;

endpackage

// File: rtl/console_fifo.sv
// -----------------------------------------------------------------------------
// console_fifo
// Parameterised synchronous FIFO used as the byte console queue. A push is
// accepted when the FIFO is not full, or when a pop happens in the same cycle
// (the slot being vacated is reused), so simultaneous push/pop on a full FIFO
// keeps the occupancy at DEPTH. The head entry is presented combinationally
// and reads as zero while the FIFO is empty.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   i_push         push request, i_pushData is the entry to store
//   i_pop          pop request (ignored while empty)
//   o_headData     entry at the head (zero when empty)
//   o_full         occupancy == DEPTH
//   o_empty        occupancy == 0
//   o_count        occupancy, log2(DEPTH)+1 bits
// DEPTH must be a power of two, at least 2.
// -----------------------------------------------------------------------------
module console_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_pushData,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_headData,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full     = (r_count == (PTR_W + 1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_headData = o_empty ? '0 : r_mem[r_rdPtr];

  // A full FIFO can still take a push when the head leaves in the same cycle
  assign w_doPop  = i_pop && !o_empty;
  assign w_doPush = i_push && (!o_full || w_doPop);

  // Storage is not reset; only the pointers decide which entries are live
  always_ff @(posedge clock) begin
    if (!reset && w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointers wrap naturally at DEPTH; count only moves on push-xor-pop
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory responder for the single-cycle MIPS core's dmem port. Holds a
// word-addressed RAM below a three-word MMIO window:
//   0xFFD STATUS  (read-only)  {23'b0, overflow, console count}
//   0xFFE CYCLES  (read-only)  free-running cycle counter
//   0xFFF CONSOLE (write)      pushes data[7:0] into the console FIFO
// Loads are registered (one-cycle latency) and read-before-write.
// Optional feature macro: DMEM_CYCLE_COUNTER_EN. When undefined there is no
// counter register and CYCLES reads as zero.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   address_dmem         word address from the processor
//   data, wren           store data and store strobe
//   q_dmem               registered load data
//   tx_data, tx_valid    console byte at the FIFO head / FIFO not empty
//   tx_ready             consumer accepts tx_data
//   overflow             sticky: a console store was dropped
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q_dmem,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              overflow
);

  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam int RAM_DEPTH = (1 << ADDR_W) - 3;

  // The window is anchored to the top of whatever address width is chosen
  localparam logic [ADDR_W-1:0] CONSOLE_ADDR = '1;
  localparam logic [ADDR_W-1:0] CYCLES_ADDR  =
    CONSOLE_ADDR - ADDR_W'(MMIO_CONSOLE - MMIO_CYCLES);
  localparam logic [ADDR_W-1:0] STATUS_ADDR  =
    CONSOLE_ADDR - ADDR_W'(MMIO_CONSOLE - MMIO_STATUS);

  logic [DATA_W-1:0] r_ram [RAM_DEPTH];
  logic [DATA_W-1:0] r_q;
  logic              r_overflow;
  rd_sel_e           w_sel;
  logic              w_pushReq;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [7:0]        w_head;
  logic [DATA_W-1:0] w_status;
  logic [DATA_W-1:0] w_cyclesRead;

  // Address decode shared by the load mux and the store paths
  always_comb begin
    w_sel = SEL_RAM;
    if (address_dmem == STATUS_ADDR) begin
      w_sel = SEL_STATUS;
    end else if (address_dmem == CYCLES_ADDR) begin
      w_sel = SEL_CYCLES;
    end else if (address_dmem == CONSOLE_ADDR) begin
      w_sel = SEL_CONSOLE;
    end
  end

  // Stores are ignored during the reset cycle, for RAM and console alike
  assign w_pushReq = wren && !reset && (w_sel == SEL_CONSOLE);
  assign w_pop     = tx_valid && tx_ready;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_consoleFifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_pushReq),
    .i_pushData (data[7:0]),
    .i_pop      (w_pop),
    .o_headData (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  // STATUS is assembled from the live (pre-edge) FIFO state
  always_comb begin
    w_status = '0;
    w_status[STATUS_OVF_BIT] = r_overflow;
    w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count);
  end

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [31:0] r_cycles;

  // Free-running counter, wraps at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycles <= '0;
    end else begin
      r_cycles <= r_cycles + 32'd1;
    end
  end

  assign w_cyclesRead = DATA_W'(r_cycles);
`else
  assign w_cyclesRead = '0;
`endif

  // RAM has no reset so it can map onto block RAM; contents survive reset
  always_ff @(posedge clock) begin
    if (!reset && wren && (w_sel == SEL_RAM)) begin
      r_ram[address_dmem] <= data;
    end
  end

  // Load register: the old RAM word is captured when a store hits the same
  // address, since the write lands on the same edge
  always_ff @(posedge clock) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      case (w_sel)
        SEL_RAM:    r_q <= r_ram[address_dmem];
        SEL_STATUS: r_q <= w_status;
        SEL_CYCLES: r_q <= w_cyclesRead;
        default:    r_q <= '0;
      endcase
    end
  end

  // A console store is dropped only when full with no pop freeing a slot
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_pushReq && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  assign q_dmem   = r_q;
  assign tx_data  = w_head;
  assign tx_valid = !w_empty;
  assign overflow = r_overflow;

endmodule
